// File: rtl/fxp_mul_pipe.sv
// Pipelined signed fixed-point multiplier with per-beat rounding, saturation and
// accumulate-with-last-result; the whole pipeline freezes under output back-pressure.
module fxp_mul_pipe #(
  parameter int N         = 16,
  parameter int FRAC_BITS = 8,
  parameter int LAT       = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         round_en,
  input  logic         sat_en,
  input  logic         acc_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ovf
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned SW = 2 * N + 1;

  // Representable result range, sign-extended to the sum width
  localparam logic signed [SW-1:0] MAX_V = {{(N + 2){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(N + 2){1'b1}}, {(N - 1){1'b0}}};

  logic                 stall;
  logic [LAT-1:1]       vld;
  logic signed [PW-1:0] prod [1:LAT-1];
  logic [2:0]           ctl  [1:LAT-1];   // {acc_en, sat_en, round_en}
  logic [N-1:0]         acc;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;

  logic signed [SW-1:0] p_x;
  logic signed [SW-1:0] half;
  logic signed [SW-1:0] rnd_c;
  logic signed [SW-1:0] shf_c;
  logic signed [SW-1:0] acc_x;
  logic signed [SW-1:0] sum_c;
  logic                 ovf_c;
  logic [N-1:0]         res_c;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  assign a_x = {{N{a[N-1]}}, a};
  assign b_x = {{N{b[N-1]}}, b};

  // Final stage: round, shift, accumulate, range check and saturate
  always_comb begin
    p_x   = {prod[LAT-1][PW-1], prod[LAT-1]};
    half  = '0;
    half[FRAC_BITS-1] = ctl[LAT-1][0];
    rnd_c = p_x + half;
    shf_c = rnd_c >>> FRAC_BITS;
    acc_x = '0;
    if (ctl[LAT-1][2]) begin
      acc_x = {{(N + 1){acc[N-1]}}, acc};
    end
    sum_c = shf_c + acc_x;
    ovf_c = (sum_c > MAX_V) || (sum_c < MIN_V);
    res_c = sum_c[N-1:0];
    if (ovf_c && ctl[LAT-1][1]) begin
      res_c = sum_c[SW-1] ? {1'b1, {(N - 1){1'b0}}} : {1'b0, {(N - 1){1'b1}}};
    end
  end

  // Pipeline registers; acc tracks the last result loaded into the output stage,
  // so a back-to-back acc_en beat sees its predecessor without extra latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= LAT - 1; k++) begin
        vld[k]  <= 1'b0;
        prod[k] <= '0;
        ctl[k]  <= '0;
      end
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else if (!stall) begin
      vld[1]  <= in_valid;
      prod[1] <= a_x * b_x;
      ctl[1]  <= {acc_en, sat_en, round_en};
      for (int k = 2; k <= LAT - 1; k++) begin
        vld[k]  <= vld[k-1];
        prod[k] <= prod[k-1];
        ctl[k]  <= ctl[k-1];
      end
      out_valid <= vld[LAT-1];
      if (vld[LAT-1]) begin
        result <= res_c;
        ovf    <= ovf_c;
        acc    <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// Bench for fxp_mul_pipe: LAT=2 and LAT=4 instances share stimulus; each is checked
// every cycle against an arithmetic reference model and an in-order expectation FIFO.
module tb_fxp_mul_pipe;

  localparam int N = 16;
  localparam int F = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic round_en = 1'b0;
  logic sat_en = 1'b0;
  logic acc_en = 1'b0;
  logic out_ready = 1'b1;

  logic [1:0] rdy;
  logic [1:0] ov;
  logic [1:0] ovfl;
  logic [1:0][N-1:0] res;

  always #5 clk = ~clk;

  fxp_mul_pipe #(.N(N), .FRAC_BITS(F), .LAT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .a(a), .b(b),
    .round_en(round_en), .sat_en(sat_en), .acc_en(acc_en), .out_valid(ov[0]),
    .out_ready(out_ready), .result(res[0]), .ovf(ovfl[0]));

  fxp_mul_pipe #(.N(N), .FRAC_BITS(F), .LAT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .a(a), .b(b),
    .round_en(round_en), .sat_en(sat_en), .acc_en(acc_en), .out_valid(ov[1]),
    .out_ready(out_ready), .result(res[1]), .ovf(ovfl[1]));

  int n_checks = 0;
  int n_fail = 0;

  logic [N-1:0] e_res   [2][64];
  bit           e_ovf   [2][64];
  int           e_stamp [2][64];
  int rd[2], wr[2], cnt[2], adv[2];
  logic [N-1:0] acc_m[2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact product, optional half-LSB bias, floor shift, add acc
  task automatic model(input logic [N-1:0] av, input logic [N-1:0] bv, input bit r,
                       input bit s, input bit ac, input logic [N-1:0] accv,
                       output logic [N-1:0] rv, output bit ovv);
    longint p;
    p = longint'($signed(av)) * longint'($signed(bv));
    if (r) p = p + (longint'(1) <<< (F - 1));
    p = p >>> F;
    if (ac) p = p + longint'($signed(accv));
    ovv = (p > 32767) || (p < -32768);
    if (ovv && s) rv = (p < 0) ? 16'h8000 : 16'h7FFF;
    else          rv = p[15:0];
  endtask

  task automatic pin(input string nm, input logic [N-1:0] av, input logic [N-1:0] bv,
                     input bit r, input bit s, input bit ac, input logic [N-1:0] accv,
                     input logic [N-1:0] exp_r, input bit exp_o);
    logic [N-1:0] rv;
    bit ovv;
    model(av, bv, r, s, ac, accv, rv, ovv);
    chk({nm, "_res"}, 32'(rv), 32'(exp_r));
    chk({nm, "_ovf"}, 32'(ovv), 32'(exp_o));
  endtask

  // One clock cycle: drive, then check both instances and record acceptances
  task automatic cyc(input bit iv, input logic [N-1:0] av, input logic [N-1:0] bv,
                     input bit r, input bit s, input bit ac, input bit ordy);
    logic [N-1:0] rv;
    bit ovv;
    bit stall;
    @(negedge clk);
    in_valid = iv; a = av; b = bv;
    round_en = r; sat_en = s; acc_en = ac; out_ready = ordy;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (ov[i]) begin
        if (cnt[i] == 0) begin
          chk($sformatf("spurious_valid_lat%0d", lat_of(i)), 32'(1), 32'(0));
        end else begin
          chk($sformatf("result_lat%0d", lat_of(i)), 32'(res[i]), 32'(e_res[i][rd[i]]));
          chk($sformatf("ovf_lat%0d", lat_of(i)), 32'(ovfl[i]), 32'(e_ovf[i][rd[i]]));
          chk($sformatf("latency_lat%0d", lat_of(i)), 32'(adv[i] - e_stamp[i][rd[i]]),
              32'(lat_of(i) - 1));
          if (ordy) begin
            rd[i] = (rd[i] + 1) % 64;
            cnt[i]--;
          end
        end
      end
      stall = ov[i] && !ordy;
      chk($sformatf("in_ready_lat%0d", lat_of(i)), 32'(rdy[i]), 32'(!stall));
      if (!stall) adv[i]++;
      if (iv && rdy[i]) begin
        model(av, bv, r, s, ac, acc_m[i], rv, ovv);
        acc_m[i] = rv;
        e_res[i][wr[i]] = rv;
        e_ovf[i][wr[i]] = ovv;
        e_stamp[i][wr[i]] = adv[i];
        wr[i] = (wr[i] + 1) % 64;
        cnt[i]++;
      end
    end
  endtask

  // Assert reset immediately (possibly mid-flight), check cleared outputs, release
  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_out_valid_lat%0d", lat_of(i)), 32'(ov[i]), 32'(0));
      chk($sformatf("rst_result_lat%0d", lat_of(i)), 32'(res[i]), 32'(0));
      chk($sformatf("rst_ovf_lat%0d", lat_of(i)), 32'(ovfl[i]), 32'(0));
      chk($sformatf("rst_in_ready_lat%0d", lat_of(i)), 32'(rdy[i]), 32'(1));
      rd[i] = 0; wr[i] = 0; cnt[i] = 0; adv[i] = 0; acc_m[i] = '0;
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [N-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'($urandom_range(0, 1023));
      3:       return 16'(-int'($urandom_range(0, 1023)));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    // Model pins against hand-computed values
    pin("pin_basic",     16'h0180, 16'h0200, 0, 1, 0, 16'h0000, 16'h0300, 0);
    pin("pin_trunc",     16'h0001, 16'h0080, 0, 1, 0, 16'h0000, 16'h0000, 0);
    pin("pin_round",     16'h0001, 16'h0080, 1, 1, 0, 16'h0000, 16'h0001, 0);
    pin("pin_neg_trunc", 16'hFFFF, 16'h0080, 0, 1, 0, 16'h0000, 16'hFFFF, 0);
    pin("pin_neg_round", 16'hFFFF, 16'h0080, 1, 1, 0, 16'h0000, 16'h0000, 0);
    pin("pin_sat_pos",   16'h7FFF, 16'h7FFF, 0, 1, 0, 16'h0000, 16'h7FFF, 1);
    pin("pin_wrap",      16'h7FFF, 16'h7FFF, 0, 0, 0, 16'h0000, 16'hFF00, 1);
    pin("pin_sat_neg",   16'h8000, 16'h7FFF, 0, 1, 0, 16'h0000, 16'h8000, 1);
    pin("pin_acc1",      16'h0100, 16'h0100, 0, 1, 1, 16'h0100, 16'h0200, 0);
    pin("pin_acc2",      16'h0200, 16'h0100, 0, 1, 1, 16'h0200, 16'h0400, 0);

    #2;
    do_reset();

    // Directed vectors
    cyc(1, 16'h0180, 16'h0200, 0, 1, 0, 1);
    cyc(0, 16'h0000, 16'h0000, 0, 0, 0, 1);
    cyc(1, 16'h0001, 16'h0080, 0, 1, 0, 1);
    cyc(1, 16'h0001, 16'h0080, 1, 1, 0, 1);
    cyc(1, 16'h7FFF, 16'h7FFF, 0, 1, 0, 1);
    cyc(1, 16'h7FFF, 16'h7FFF, 0, 0, 0, 1);
    cyc(1, 16'h8000, 16'h7FFF, 0, 1, 0, 1);
    cyc(1, 16'h0100, 16'h0100, 0, 1, 0, 1);
    cyc(1, 16'h0100, 16'h0100, 0, 1, 1, 1);
    cyc(1, 16'h0200, 16'h0100, 0, 1, 1, 1);
    for (int k = 0; k < 6; k++) cyc(0, 16'h0000, 16'h0000, 0, 0, 0, 1);

    // Six-beat stream with three cycles of back-pressure in the middle
    for (int k = 0; k < 9; k++) begin
      cyc(k < 6, 16'(16'h0040 * (k + 1)), 16'h0300, k[0], 1, k[1], !(k >= 3 && k <= 5));
    end
    for (int k = 0; k < 6; k++) cyc(0, 16'h0000, 16'h0000, 0, 0, 0, 1);

    // Reset with two beats in flight in the LAT=4 instance
    cyc(1, 16'h0300, 16'h0200, 0, 1, 0, 1);
    cyc(1, 16'h0500, 16'h0100, 0, 1, 1, 1);
    cyc(0, 16'h0000, 16'h0000, 0, 0, 0, 1);
    do_reset();
    cyc(1, 16'h0180, 16'h0200, 0, 1, 1, 1);
    for (int k = 0; k < 6; k++) cyc(0, 16'h0000, 16'h0000, 0, 0, 0, 1);

    // Randomized traffic with bubbles and back-pressure
    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom),
          1'($urandom), $urandom_range(0, 9) < 7);
    end
    for (int k = 0; k < 12; k++) cyc(0, 16'h0000, 16'h0000, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("drained_lat%0d", lat_of(i)), 32'(cnt[i]), 32'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
